rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//  Parametrised N:1 streaming multiplexer; successor to the fixed 8:1 select-line mux.
//  Replaces external select lines with internal arbitration: round-robin or fixed priority.
//  Uses a valid/ready handshake and holds the grant for a whole packet (in_last marks the end).
//  Registered output stage; sits between per-channel producers and one shared consumer.
// PARAMETERS
//  NUM_CH    8   number of input channels (>=1)
//  DATA_W    8   data width per channel
//  ARB_MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  CH_W      derived: max(1, $clog2(NUM_CH)); not user-set
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous reset, active-high
//  in_valid   in   NUM_CH         per-channel valid
//  in_data    in   NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
//  in_last    in   NUM_CH         per-channel end-of-packet flag
//  in_ready   out  NUM_CH         per-channel ready; at most one bit set
//  out_valid  out  1              output beat valid
//  out_data   out  DATA_W         output beat data
//  out_last   out  1              output end-of-packet flag
//  out_ch     out  CH_W           source channel of the current output beat
//  out_ready  in   1              consumer ready
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=NUM_CH-1.
//    Channel 0 therefore wins first. in_ready=0 while rst=1.
//  - A transfer occurs on any edge where valid & ready are both 1. No beat is dropped or duplicated.
//  - load_en = !out_valid | out_ready. The out_ready->in_ready path is combinational by design.
//  - FSM IDLE:
//    - gnt = arbiter pick over in_valid. RR searches from rr_ptr+1 and wraps; FIXED picks the lowest set index.
//    - in_ready[gnt] = load_en & |in_valid.
//    - On acceptance with in_last=1: stay in IDLE and set rr_ptr<=gnt.
//    - On acceptance with in_last=0: go to LOCKED and set cur_ch<=gnt.
//  - FSM LOCKED:
//    - Only cur_ch may be ready: in_ready[cur_ch] = load_en. Other channels are blocked even if valid.
//    - Accepted beat with in_last=1: go to IDLE and set rr_ptr<=cur_ch.
//  - Output register:
//    - On acceptance, load out_data/out_last/out_ch from the granted channel and set out_valid=1 on the next edge.
//    - If out_ready=1 and nothing is accepted, out_valid goes to 0.
//    - Latency: exactly 1 cycle from input accept to out_valid.
//    - Throughput: 1 beat/cycle when out_ready stays high.
//  - Stall: while out_valid=1 and out_ready=0, out_* are held stable and all in_ready=0.
//  - Simultaneous pop and push on one edge: new beat replaces old; no bubble.
//  - Single-beat packets (in_last=1 on first beat) never enter LOCKED.
//  - Channel dropping in_valid mid-packet in LOCKED: stall, remain locked, no re-arbitration.
//  - Reset mid-packet: lock is abandoned and the output beat is discarded; nothing is flushed.
//  - NUM_CH=1: arbiter degenerates to that channel and out_ch is always 0.
//  - Data and flags of non-granted channels never affect any output.
// STRUCTURE
//  - mux_pkg: ARB_RR=0, ARB_FIXED=1, state encoding (IDLE=1'b0, LOCKED=1'b1), and a function
//    clog2_min1(n) that returns max(1, $clog2(n)).
//  - Sub-module rr_arbiter #(NUM_CH, ARB_MODE):
//    - Inputs: req, ptr. Output: one-hot gnt plus encoded gnt_idx.
//    - Purely combinational; RR implemented as a double-width masked find-first.
//  - Top: FSM, rr_ptr/cur_ch registers, in_ready decode, DATA_W output register, N:1 data select by index.
// TESTING  (NUM_CH=8, DATA_W=8, ARB_MODE=0 unless stated)
//  1. Reset, then in_valid=8'hFF, all in_last=1, out_ready=1.
//     -> out_ch sequence 0,1,2..7,0, one beat/cycle; out_valid rises 1 cycle after the first accept.
//  2. ch3 sends a 4-beat packet (data 0x30..0x33, last on 0x33) while ch5 is continuously valid.
//     -> out_data 30,31,32,33 all with out_ch=3, then ch5's beat; in_ready[5]=0 during the packet.
//  3. Hold out_ready=0 for 5 cycles with out_valid=1, data 0xA5.
//     -> out_data stays 0xA5, in_ready=0; release gives exactly one 0xA5 and no duplicate.
//  4. ARB_MODE=1, in_valid=8'b1010_0100, all single-beat.
//     -> ch2 wins every cycle while valid; ch5 is served only after ch2 drops valid.
//  5. Assert rst in the middle of a ch6 packet (beat 2 of 4).
//     -> next cycle out_valid=0, state IDLE; with ch1 and ch6 valid after reset, ch1 is granted first.
//  6. Random valid/last/out_ready for 10k cycles.
//     -> scoreboard: per-channel order preserved, packets never interleaved, $onehot0(in_ready) always.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin streaming multiplexer.
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   state_t            : packet-lock FSM encoding
//   clog2_min1(n)      : index width that never collapses to zero bits
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter.
//   req     in   NUM_CH  request vector
//   ptr     in   CH_W    last served channel (round-robin starts after it)
//   gnt     out  NUM_CH  one-hot grant, zero when no request
//   gnt_idx out  CH_W    encoded grant, zero when no request
// Round-robin duplicates the request vector and masks off every bit at or
// below ptr; the first set bit of the result is the next channel after ptr,
// and the upper copy provides the wrap-around without a second search.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH   = 8,
  parameter  int ARB_MODE = ARB_RR,
  localparam int CH_W     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [2*NUM_CH-1:0] dbl_req;
  logic [2*NUM_CH-1:0] masked;
  logic                found;

  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    dbl_req = {req, req};
    masked  = '0;
    gnt_idx = '0;
    gnt     = '0;
    found   = 1'b0;

    for (int j = 0; j < 2*NUM_CH; j++) begin
      masked[j] = dbl_req[j] & (j > int'(ptr));
    end

    if (ARB_MODE == ARB_FIXED) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && req[j]) begin
          gnt_idx = CH_W'(j);
          found   = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < 2*NUM_CH; j++) begin
        if (!found && masked[j]) begin
          gnt_idx = CH_W'((j >= NUM_CH) ? j - NUM_CH : j);
          found   = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = found && (gnt_idx == CH_W'(i));
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with packet-level grant locking and a
// registered output stage.
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   per-channel handshake (at most one ready bit set)
//   in_data          channel i at [i*DATA_W +: DATA_W]
//   in_last          per-channel end-of-packet flag
//   out_valid/ready  consumer handshake
//   out_data/last    registered beat and its end-of-packet flag
//   out_ch           source channel of the beat on out_data
// The output register reloads whenever it is empty or being drained, so
// out_ready reaches in_ready combinationally and a full register still
// sustains one beat per cycle.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int NUM_CH   = 8,
  parameter  int DATA_W   = 8,
  parameter  int ARB_MODE = ARB_RR,
  localparam int CH_W     = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  state_t            state, state_d;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CH_W-1:0]   cur_ch, cur_ch_d;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   sel_ch;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              load_en;
  logic              accept;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign load_en = !out_valid || out_ready;

  // Ready decode and source select. While locked only the owning channel
  // is considered, so other channels cannot slip in when it goes idle.
  always_comb begin
    in_ready = '0;
    sel_ch   = (state == LOCKED) ? cur_ch : gnt_idx;
    if (!rst) begin
      if (state == IDLE) begin
        in_ready = load_en ? gnt : '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          in_ready[i] = load_en && (cur_ch == CH_W'(i));
        end
      end
    end

    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == CH_W'(i)) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
        sel_last = in_last[i];
      end
    end
  end

  assign accept = |(in_valid & in_ready);

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    cur_ch_d = cur_ch;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_d = gnt_idx;
          end else begin
            state_d  = LOCKED;
            cur_ch_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = cur_ch;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      cur_ch    <= '0;
      out_valid <= 1'b0;
      // NOTE: the data register is reset too because out_data is visible
      // and must read zero after reset, not just be qualified by out_valid.
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      cur_ch <= cur_ch_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_ch    <= sel_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed round-robin, packet lock,
// stall, reset mid-packet, fixed-priority, then a randomised run checked by
// per-channel scoreboards.
module tb_rr_stream_mux;
  import mux_pkg::*;

  localparam int N = 8;
  localparam int W = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_last, out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_ch;

  logic [N-1:0]   fx_in_valid, fx_in_last, fx_in_ready;
  logic [N*W-1:0] fx_in_data;
  logic           fx_out_valid, fx_out_last, fx_out_ready;
  logic [W-1:0]   fx_out_data;
  logic [2:0]     fx_out_ch;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [8:0] ch_q [N][$];
  bit   rnd_mode = 1'b0;

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(ARB_RR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(fx_in_valid), .in_data(fx_in_data),
    .in_last(fx_in_last), .in_ready(fx_in_ready), .out_valid(fx_out_valid),
    .out_data(fx_out_data), .out_last(fx_out_last), .out_ch(fx_out_ch),
    .out_ready(fx_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic [7:0] data, input logic last);
    exp_t e;
    e.ch   = 3'(ch);
    e.data = data;
    e.last = last;
    return e;
  endfunction

  task automatic set_ch(input int i, input logic [7:0] data, input logic last);
    in_data[i*W +: W] = data;
    in_last[i]        = last;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Serve single-beat offers until every valid has been accepted.
  task automatic run_singles(input int bound);
    logic [N-1:0] acc;
    int cyc = 0;
    while (in_valid != '0 && cyc < bound) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      next();
      in_valid = in_valid & ~acc;
      cyc++;
    end
    check("singles_done", in_valid, 0);
  endtask

  // Output monitor: compares every delivered beat against the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [8:0] got;
    bit         pkt_open = 1'b0;
    logic [2:0] pkt_ch = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("rst_ready", in_ready, 0);
        pkt_open = 1'b0;
      end else if (rst === 1'b0) begin
        check("onehot_ready", 32'($onehot0(in_ready)), 1);
        if (out_valid && out_ready) begin
          if (rnd_mode) begin
            if (ch_q[out_ch].size() == 0) begin
              check("rnd_unexpected", {out_ch, out_data}, 32'hFFFF);
            end else begin
              got = ch_q[out_ch].pop_front();
              check("rnd_beat", {out_last, out_data}, got);
            end
          end else if (exp_q.size() == 0) begin
            check("unexpected_beat", {out_ch, out_data}, 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_ch", out_ch, e.ch);
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
          end
          if (pkt_open) check("no_interleave", out_ch, pkt_ch);
          pkt_open = !out_last;
          pkt_ch   = out_ch;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [N-1:0] acc;
    int           beat;
    bit           done;
    int           seq [N];
    bit           prod_open [N];
    bit           draining;
    logic [7:0]   d;
    logic         l;
    int           total;

    rst = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    fx_in_valid = '0; fx_in_last = '0; fx_in_data = '0; fx_out_ready = 1'b0;
    repeat (3) next();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_ch", out_ch, 0);
    next();

    // Test 1: all channels valid, single-beat: 0..7,0 one per cycle.
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < N; i++) set_ch(i, 8'(i*16 + 5), 1'b1);
    for (int k = 0; k < 9; k++) exp_q.push_back(mk(k % N, 8'((k % N)*16 + 5), 1'b1));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t1_ready", in_ready, 32'(1 << (k % N)));
      if (k == 0) check("t1_lat_before", out_valid, 0);
      if (k == 1) check("t1_lat_after", out_valid, 1);
      next();
    end
    in_valid = '0;
    repeat (3) next();
    check("t1_empty", exp_q.size(), 0);

    // Test 2: 4-beat packet on ch3 locks out a continuously valid ch5.
    set_ch(3, 8'h30, 1'b0);
    set_ch(5, 8'h50, 1'b1);
    in_valid = 8'h28;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(3, 8'(8'h30 + b), b == 3));
    exp_q.push_back(mk(5, 8'h50, 1'b1));
    beat = 0; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (beat < 4) check("t2_ch5_blocked", in_ready[5], 0);
      acc = in_valid & in_ready;
      next();
      if (acc[3]) begin
        beat++;
        if (beat == 4) in_valid[3] = 1'b0;
        else set_ch(3, 8'(8'h30 + beat), beat == 3);
      end
      if (acc[5]) begin
        in_valid[5] = 1'b0;
        done = 1'b1;
      end
    end
    check("t2_done", done, 1);
    repeat (3) next();
    check("t2_empty", exp_q.size(), 0);

    // Test 3: stall with 0xA5 held, then release with a waiting beat.
    out_ready = 1'b0;
    set_ch(1, 8'hA5, 1'b1);
    in_valid = 8'h02;
    exp_q.push_back(mk(1, 8'hA5, 1'b1));
    exp_q.push_back(mk(2, 8'h22, 1'b1));
    @(negedge clk);
    check("t3_accept", in_ready, 8'h02);
    next();
    in_valid = 8'h04;
    set_ch(2, 8'h22, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 8'hA5);
      check("t3_hold_ready", in_ready, 0);
      next();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", in_ready, 8'h04);
    next();
    in_valid = '0;
    repeat (3) next();
    check("t3_empty", exp_q.size(), 0);

    // Test 5: reset during ch6 packet after its second beat.
    set_ch(6, 8'h60, 1'b0);
    in_valid = 8'h40;
    exp_q.push_back(mk(6, 8'h60, 1'b0));
    beat = 0;
    for (int cyc = 0; cyc < 10 && beat < 2; cyc++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      next();
      if (acc[6]) begin
        beat++;
        set_ch(6, 8'(8'h60 + beat), 1'b0);
      end
    end
    check("t5_beats", beat, 2);
    rst = 1'b1;
    next();
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    next();
    rst = 1'b0;
    set_ch(1, 8'h11, 1'b1);
    set_ch(6, 8'h66, 1'b1);
    in_valid = 8'h42;
    exp_q.push_back(mk(1, 8'h11, 1'b1));
    exp_q.push_back(mk(6, 8'h66, 1'b1));
    @(negedge clk);
    check("t5_first_grant", in_ready, 8'h02);
    acc = in_valid & in_ready;
    next();
    in_valid = in_valid & ~acc;
    run_singles(10);
    repeat (3) next();
    check("t5_empty", exp_q.size(), 0);

    // Test 4: fixed priority, ch2 beats ch5 and ch7 until it drops.
    fx_out_ready = 1'b1;
    fx_in_last = 8'hFF;
    for (int i = 0; i < N; i++) fx_in_data[i*W +: W] = 8'(i*16 + 5);
    fx_in_valid = 8'hA4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_ch2_ready", fx_in_ready, 8'h04);
      if (k > 0) check("t4_ch2_out", {fx_out_valid, fx_out_ch}, {1'b1, 3'd2});
      next();
    end
    fx_in_valid = 8'hA0;
    @(negedge clk);
    check("t4_ch5_ready", fx_in_ready, 8'h20);
    next();
    fx_in_valid = 8'h80;
    @(negedge clk);
    check("t4_ch5_out", {fx_out_valid, fx_out_ch, fx_out_data}, {1'b1, 3'd5, 8'h55});
    check("t4_ch7_ready", fx_in_ready, 8'h80);
    next();
    fx_in_valid = '0;
    repeat (2) next();

    // Test 6: random traffic with per-channel scoreboards.
    rnd_mode = 1'b1;
    in_valid = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      prod_open[i] = 1'b0;
    end
    draining = 1'b0;
    for (int cyc = 0; cyc < 10300; cyc++) begin
      if (cyc == 10000) draining = 1'b1;
      @(negedge clk);
      acc = in_valid & in_ready;
      next();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && (draining ? prod_open[i] : ($urandom_range(0, 2) == 0))) begin
          d = {3'(i), 5'(seq[i])};
          seq[i]++;
          l = draining ? 1'b1 : ($urandom_range(0, 3) == 0);
          set_ch(i, d, l);
          ch_q[i].push_back({l, d});
          prod_open[i] = !l;
          in_valid[i] = 1'b1;
        end
      end
      out_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    repeat (3) next();
    total = 0;
    for (int i = 0; i < N; i++) total += ch_q[i].size();
    check("t6_drained", total, 0);
    check("t6_idle", {out_valid, in_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
